bus_arbiter_rr: RTL
===================

Name: bus_arbiter_rr

Overview:
Parametrised round-robin bus arbiter for N bus masters, the next-generation arbiter of the bus subsystem. It grants one master at a time with registered one-hot and encoded grant outputs. The owner keeps the bus while it requests. A configurable maximum-tenure counter forces rotation so that no master is starved. A per-master lock input exempts atomic sequences from forced rotation.

Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..16.
- IDX_W, 2: width of the grant index; must equal clog2(NUM_MASTERS).
- MAX_HOLD, 16: maximum consecutive grant cycles before forced rotation; 0 disables the limit.
- CNT_W, 5: tenure counter width; must hold MAX_HOLD.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_MASTERS  request vector; bit i is master i.
- lock  in  NUM_MASTERS  bit i set: master i must not be preempted by MAX_HOLD.
- gnt  out  NUM_MASTERS  registered one-hot grant.
- gnt_idx  out  IDX_W  encoded index of the granted master; valid when gnt_valid=1.
- gnt_valid  out  1  some master currently holds the bus.
- preempt  out  1  one-cycle pulse: the previous grant was removed by MAX_HOLD expiry.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset; all registers clear on the rising clk edge with reset=1.
- Reset values:
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, tenure counter=0.
  - last_owner=NUM_MASTERS-1, so master 0 has highest priority after reset.
- Reset mid-tenure drops the grant on the next edge. No partial state survives.
- States:
  - IDLE (gnt_valid=0).
  - OWNED (gnt_valid=1, owner = gnt_idx).
- Search order: start at last_owner+1, wrap modulo NUM_MASTERS, and take the first master with req set. The current owner is always last in the order.
- IDLE:
  - If any req is set, the winner is granted on the next edge.
  - Latency: req sampled at edge t gives gnt at edge t+1, i.e. one cycle.
  - On grant: tenure counter=1, last_owner=winner.
- OWNED, req[owner]=0:
  - Release on the next edge.
  - If another master is requesting, switch directly to the search winner. There are no dead cycles between owners; gnt changes from one bit to another in a single edge.
  - If no master is requesting, go to IDLE with gnt=0. last_owner is retained.
- OWNED, req[owner]=1:
  - The owner holds the bus. The tenure counter increments and saturates at MAX_HOLD.
- Forced rotation happens when all of the following hold:
  - MAX_HOLD != 0;
  - counter == MAX_HOLD;
  - lock[owner]=0;
  - at least one other master is requesting.
- On forced rotation:
  - The grant moves to the search winner, excluding the owner, on the next edge.
  - preempt=1 for exactly that one cycle.
  - The counter reloads to 1.
- Expiry with no other requester: the owner keeps the bus and the counter stays saturated. Rotation fires on the first cycle another master requests.
- lock[owner]=1 suppresses forced rotation only. Release through req[owner]=0 still applies.
- Dropping lock while the counter is saturated enables rotation in that same evaluation cycle.
- lock bits of non-owners are ignored.
- Simultaneous requests: the round-robin order decides. There is no fixed priority except immediately after reset.
- Output invariants:
  - gnt is always one-hot or zero.
  - gnt_valid equals the OR of gnt.
  - gnt_idx matches the set bit of gnt. gnt_idx holds its last value while gnt_valid=0.
- A grant is never given to a master whose req was 0 at the sampling edge.

Test Plan:
1. Reset, then req=4'b1111 held, MAX_HOLD=16, lock=0 → gnt=0001 for 16 cycles; preempt pulses; gnt=0010 for 16 cycles; then 0100, then 1000, then 0001.
2. Master 2 holds the bus; req changes from 0100 to 1001 in the same cycle → next edge gnt=1000 (search from 3); preempt=0; no idle cycle.
3. Master 1 owns the bus with lock=0010 and req=0011 held for 40 cycles → gnt stays 0010 all 40 cycles. Drop lock → the following edge gives gnt=0001 and preempt=1.
4. Only master 3 requests, held for 30 cycles → gnt=1000 throughout and the counter saturates at 16. Master 0 asserts req → gnt=0001 one edge later with preempt=1.
5. All req=0 after master 2's tenure → gnt=0, gnt_valid=0. Then req=0101 → gnt=0001 (search from 3).
6. Reset asserted for one cycle during a grant to master 1 → outputs zero on the next edge. With req=0010 still held, gnt=0010 follows one edge after reset deasserts.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter for NUM_MASTERS masters with registered grants,
// tenure-limited ownership (MAX_HOLD) and per-master lock against preemption.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_HOLD    = 16,
    parameter int CNT_W       = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] lock,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   gnt_valid,
    output logic                   preempt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0]       LAST_IDX      = IDX_W'(NUM_MASTERS - 1);
    localparam logic [IDX_W-1:0]       IDX_ONE       = IDX_W'(1);
    localparam logic [CNT_W-1:0]       CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_ZERO      = {CNT_W{1'b0}};
    localparam bit                     HOLD_LIMIT_EN = (MAX_HOLD != 32'sd0);
    // With the limit disabled the counter just saturates at its full range.
    localparam logic [CNT_W-1:0]       CNT_CAP       = HOLD_LIMIT_EN ? CNT_W'(MAX_HOLD) : {CNT_W{1'b1}};
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0      = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NUM_MASTERS-1:0] GNT_ZERO      = {NUM_MASTERS{1'b0}};

    // First candidate after 'last', wrapping; 'last' itself is visited last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] cand,
                                                 input logic [IDX_W-1:0]       last);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        idx   = last;
        pick  = last;
        found = 1'b0;
        for (int off = 0; off < NUM_MASTERS; off++) begin
            if (idx == LAST_IDX) begin
                idx = {IDX_W{1'b0}};
            end else begin
                idx = idx + IDX_ONE;
            end
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    state_t                 state_r, state_s;
    logic [NUM_MASTERS-1:0] gnt_r, gnt_s;
    logic [IDX_W-1:0]       gnt_idx_r, gnt_idx_s;
    logic                   gnt_valid_r, gnt_valid_s;
    logic                   preempt_r, preempt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [IDX_W-1:0]       last_r, last_s;

    logic [NUM_MASTERS-1:0] others_s;
    logic [IDX_W-1:0]       win_s;
    logic                   any_other_s;
    logic                   expired_s;
    logic                   take_s;

    // Next-state and next-output decode for the IDLE/OWNED arbitration FSM.
    always_comb begin
        // Masking the owner's bit makes the owner implicitly last in search order.
        others_s    = req & ~gnt_r;
        win_s       = rr_pick(others_s, last_r);
        any_other_s = |others_s;
        expired_s   = HOLD_LIMIT_EN && (cnt_r == CNT_CAP);

        state_s     = state_r;
        gnt_s       = gnt_r;
        gnt_idx_s   = gnt_idx_r;
        gnt_valid_s = gnt_valid_r;
        preempt_s   = 1'b0;
        cnt_s       = cnt_r;
        last_s      = last_r;
        take_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (any_other_s) begin
                    take_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!req[gnt_idx_r]) begin
                    if (any_other_s) begin
                        take_s = 1'b1;
                    end else begin
                        state_s     = ST_IDLE;
                        gnt_s       = GNT_ZERO;
                        gnt_valid_s = 1'b0;
                        cnt_s       = CNT_ZERO;
                    end
                end else if (expired_s && !lock[gnt_idx_r] && any_other_s) begin
                    take_s    = 1'b1;
                    preempt_s = 1'b1;
                end else if (cnt_r != CNT_CAP) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                gnt_s       = GNT_ZERO;
                gnt_valid_s = 1'b0;
                cnt_s       = CNT_ZERO;
            end
        endcase

        if (take_s) begin
            state_s     = ST_OWNED;
            gnt_s       = ONE_HOT0 << win_s;
            gnt_idx_s   = win_s;
            gnt_valid_s = 1'b1;
            cnt_s       = CNT_ONE;
            last_s      = win_s;
        end else begin
            last_s = last_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            gnt_r       <= GNT_ZERO;
            gnt_idx_r   <= {IDX_W{1'b0}};
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
            cnt_r       <= CNT_ZERO;
            last_r      <= LAST_IDX;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_idx_r   <= gnt_idx_s;
            gnt_valid_r <= gnt_valid_s;
            preempt_r   <= preempt_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign preempt   = preempt_r;

endmodule
